// File: rtl/m1_session_arbiter.sv
// Round-robin arbiter and session sequencer for the shared ticket/payment unit.
// One kiosk at a time owns the unit for ticket -> two payments -> validate, with idle timeout and abort.
module m1_session_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    R,
  input  logic [NREQ-1:0]         req,
  input  logic                    iT,
  input  logic                    iM,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    T,
  output logic                    V,
  output logic [1:0]              D,
  output logic                    abort
);

  localparam int OW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, TICKET, PAY1, PAY2, DONE, ABORT} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [OW-1:0] winner;
  logic [OW-1:0] idx;
  logic [OW:0]   sum;
  logic          found;
  logic          advance;
  logic [OW-1:0] owner_next;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  // First requester at or after ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    sum    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (OW+1)'(i);
      if (sum >= (OW+1)'(NREQ)) sum = sum - (OW+1)'(NREQ);
      idx = sum[OW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign owner_next = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);
  assign advance    = ((state_q == TICKET) && iT) ||
                      (((state_q == PAY1) || (state_q == PAY2)) && iM);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = TICKET;
          owner_d = winner;
          timer_d = '0;
        end
      end
      TICKET, PAY1, PAY2: begin
        // Owner dropping its request outranks both progress and the timeout.
        if (!req[owner_q]) begin
          state_d = ABORT;
          timer_d = '0;
        end else if (advance) begin
          timer_d = '0;
          case (state_q)
            TICKET:  state_d = PAY1;
            PAY1:    state_d = PAY2;
            default: state_d = DONE;
          endcase
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          state_d = ABORT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE, ABORT: begin
        state_d = IDLE;
        ptr_d   = owner_next;
        timer_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    busy  = 1'b0;
    T     = 1'b0;
    V     = 1'b0;
    D     = 2'b00;
    abort = 1'b0;
    if (state_q != IDLE) begin
      busy = 1'b1;
      gnt  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    end
    case (state_q)
      PAY1:  T = 1'b1;
      PAY2: begin
        T = 1'b1;
        D = 2'b01;
      end
      DONE: begin
        T = 1'b1;
        D = 2'b10;
        V = 1'b1;
      end
      ABORT:   abort = 1'b1;
      default: ;
    endcase
  end

  assign owner = owner_q;

endmodule
